// File: rtl/residue_det_pkg.sv
// ----------------------------------------------------------------------------
// residue_det_pkg
// Shared types and width helpers for the serial residue detector family.
//   state_e      : ACCUM (collecting bits) / HOLD (result pending)
//   residue_rw() : residue register width for a given divisor
//   count_width(): bit-counter width for a given frame width
// ----------------------------------------------------------------------------
package residue_det_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // A residue is always < divisor, so $clog2(divisor) bits hold it.
    function automatic int unsigned residue_rw(input int unsigned divisor);
        return $clog2(divisor);
    endfunction

    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/residue_step.sv
// ----------------------------------------------------------------------------
// residue_step
// One MSB-first residue update: next = (2*res + bit) mod DIVISOR.
// Because res < DIVISOR, 2*res + bit < 2*DIVISOR, so one conditional
// subtract suffices.
// Ports:
//   res_i  in  RW  current residue (< DIVISOR)
//   bit_i  in  1   incoming bit
//   res_o  out RW  updated residue
// ----------------------------------------------------------------------------
module residue_step
    import residue_det_pkg::*;
#(
    parameter  int unsigned DIVISOR = 4,
    localparam int unsigned RW      = residue_rw(DIVISOR)
) (
    input  logic [RW-1:0] res_i,
    input  logic          bit_i,
    output logic [RW-1:0] res_o
);

    localparam logic [RW:0] DIV_T = (RW + 1)'(DIVISOR);

    logic [RW:0] t;

    always_comb begin
        t = {res_i, bit_i};
        if (t >= DIV_T) begin
            res_o = RW'(t - DIV_T);
        end else begin
            res_o = RW'(t);
        end
    end

endmodule

// File: rtl/residue_detector.sv
// ----------------------------------------------------------------------------
// residue_detector
// Serial divisibility detector: takes a WIDTH-bit unsigned word one bit per
// cycle (MSB first) and reports whether it is divisible by DIVISOR.
// Optional feature macro: RESIDUE_DET_VALUE_EN adds the out_residue port.
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   in_valid     in   1   in_bit valid this cycle
//   in_bit       in   1   next frame bit, MSB first
//   in_ready     out  1   block accepts a bit (state == ACCUM)
//   in_clr       in   1   abort partial frame (ignored while holding a result)
//   out_valid    out  1   result available
//   out_hit      out  1   frame value mod DIVISOR == 0
//   out_residue  out  RW  final residue (only with RESIDUE_DET_VALUE_EN)
//   out_ready    in   1   consumer takes the result
// ----------------------------------------------------------------------------
module residue_detector
    import residue_det_pkg::*;
#(
    parameter  int unsigned WIDTH   = 5,
    parameter  int unsigned DIVISOR = 4,
    localparam int unsigned RW      = residue_rw(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    input  logic          in_clr,
    output logic          out_valid,
    output logic          out_hit,
`ifdef RESIDUE_DET_VALUE_EN
    output logic [RW-1:0] out_residue,
`endif
    input  logic          out_ready
);

    localparam int unsigned   CW   = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e        state_q;
    logic [RW-1:0] res_q;
    logic [RW-1:0] res_d;
    logic [CW-1:0] cnt_q;
    logic          valid_q;
    logic          hit_q;
`ifdef RESIDUE_DET_VALUE_EN
    logic [RW-1:0] resout_q;
`endif

    residue_step #(
        .DIVISOR (DIVISOR)
    ) u_step (
        .res_i (res_q),
        .bit_i (in_bit),
        .res_o (res_d)
    );

    // Depends on state only: no path from in_valid or out_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = valid_q;
    assign out_hit   = hit_q;
`ifdef RESIDUE_DET_VALUE_EN
    assign out_residue = resout_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            res_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
`ifdef RESIDUE_DET_VALUE_EN
            resout_q <= '0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    // clr wins: any bit offered alongside it is dropped.
                    if (in_clr) begin
                        res_q <= '0;
                        cnt_q <= '0;
                    end else if (in_valid) begin
                        if (cnt_q == LAST) begin
                            hit_q    <= (res_d == '0);
`ifdef RESIDUE_DET_VALUE_EN
                            resout_q <= res_d;
`endif
                            valid_q  <= 1'b1;
                            state_q  <= HOLD;
                            res_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            res_q <= res_d;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // Outputs frozen until the consumer takes them.
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: doc/residue_detector.md
# residue_detector

Parametrised serial residue detector: accepts a WIDTH-bit unsigned word one bit per cycle, MSB first, and reports whether the word is divisible by DIVISOR. It is the sequential, parametrised successor to the fixed 5-bit combinational value-set detector. It sits between a serial source and a consumer, and uses valid/ready on both sides so either side can stall.

## Interface
- WIDTH, 5, bits per frame; must be ≥ 1
- DIVISOR, 4, modulus; must be ≥ 2
- RW, $clog2(DIVISOR), residue register width; derived, not overridden
---
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  next bit of the frame, MSB first
- in_ready  out  1  block accepts a bit this cycle
- in_clr  in  1  abort the partial frame
- out_valid  out  1  result is available
- out_hit  out  1  1 when the frame value mod DIVISOR == 0
- out_ready  in  1  consumer takes the result
- out_residue  out  RW  final residue; present only with RESIDUE_DET_VALUE_EN

## Operation
- States:
  - ACCUM: collecting bits.
  - HOLD: result pending.
- Reset values: state = ACCUM, residue = 0, bit count = 0, out_valid = 0, out_hit = 0, out_residue = 0.
- in_ready = (state == ACCUM). A bit is accepted when in_valid && in_ready.
- On an accepted bit:
  - Compute t = 2·residue + in_bit, RW+1 bits wide.
  - New residue = t − DIVISOR if t ≥ DIVISOR, else t. A single conditional subtract is sufficient because residue < DIVISOR.
  - Bit count increments.
- When the accepted bit is the WIDTH-th bit of the frame:
  - Register out_hit = (new residue == 0). With the macro, also register out_residue = new residue.
  - Set out_valid = 1 and move to HOLD.
  - Clear residue and bit count to 0.
- In HOLD:
  - out_valid, out_hit and out_residue stay stable until out_valid && out_ready.
  - On that handshake, out_valid drops to 0 and the state returns to ACCUM.
- in_clr in ACCUM: residue and bit count go to 0. Any bit offered in the same cycle is dropped, so clr wins over in_valid.
- in_clr in HOLD: ignored. A pending result is never lost.
- rst at any point, including mid-frame or in HOLD, returns all state to reset values on the next edge.
- Bit count wraps only through frame completion; it never exceeds WIDTH−1.

## Timing
- Result latency: out_valid is high in the cycle after the last bit is accepted.
- Minimum frame period is WIDTH+1 cycles: WIDTH accept cycles plus at least one HOLD cycle.
- out_ready may already be high when out_valid rises; HOLD then lasts exactly 1 cycle.
- in_ready is combinational from state only. It has no combinational path from in_valid or out_ready.

## Configuration
- RESIDUE_DET_VALUE_EN defined:
  - The out_residue port exists.
  - It is registered with out_hit and held stable in HOLD.
- RESIDUE_DET_VALUE_EN undefined:
  - The port and its register are absent.
  - Hit/valid behaviour is identical.

## Structure
- Package residue_det_pkg holds:
  - the state enum (ACCUM, HOLD);
  - a function computing RW from DIVISOR;
  - the count width as $clog2(WIDTH+1).
- One combinational sub-module, residue_step (inputs residue, bit; output next residue), implements the double-add-subtract step. It is reused by future parallel-unrolled variants.

## Test plan
- WIDTH=5, DIVISOR=3, bits 0,1,1,1,1 (15) with out_ready=1 → out_valid 1 cycle after the 5th bit, out_hit=1, out_residue=0.
- WIDTH=5, DIVISOR=3, bits 1,0,1,1,0 (22) → out_hit=0, out_residue=1.
- WIDTH=5, DIVISOR=4, bits 1,1,1,0,0 (28) → out_hit=1; then bits 0,0,1,1,0 (6) → out_hit=0, out_residue=2.
- Backpressure: hold out_ready=0 for 3 cycles after a result, offering bits throughout → in_ready=0, outputs stable, no bits consumed. Bits are consumed from the cycle after out_ready=1.
- Abort: accept 1,1, then in_clr=1 with in_valid=1, then bits 0,0,1,0,0 (4), DIVISOR=3 → out_hit=0, out_residue=1. The bit offered with clr is dropped.
- Reset: assert rst after 3 bits, and separately while in HOLD → next cycle out_valid=0 and in_ready=1; a following frame of 00000 → out_hit=1.
